// File: rtl/draw_port_arbiter_if.sv
// Plot-port bundle between the three drawing requesters and the arbiter.
//   master : requester side. Drives req/done/pixel streams and watches the
//            grant, the forwarded plot port and the status flags.
//   slave  : arbiter side. The mirror image of master.
// Requester i uses x_in[8i+7:8i], y_in[7i+6:7i], color_in[3i+2:3i] and plot_in[i].
interface draw_port_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  done;
  logic [23:0] x_in;
  logic [20:0] y_in;
  logic [8:0]  color_in;
  logic [2:0]  plot_in;
  logic [2:0]  grant;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  color_out;
  logic        writeEn;
  logic        busy;
  logic        timeout_err;

  modport master (
    output req, done, x_in, y_in, color_in, plot_in,
    input  grant, x_out, y_out, color_out, writeEn, busy, timeout_err
  );

  modport slave (
    input  req, done, x_in, y_in, color_in, plot_in,
    output grant, x_out, y_out, color_out, writeEn, busy, timeout_err
  );
endinterface

// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter for the single VGA adapter plot port.
// Requesters: 0 = top paddle, 1 = bottom paddle, 2 = ball.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   bus (slave) : req/done/pixel streams in; registered one-hot grant,
//                 forwarded x/y/colour/writeEn, busy and sticky timeout_err out
// A grant lasts until the owner pulses done, drops req, or the watchdog
// reaches TIMEOUT_CYCLES-1. Every release is followed by one blank GAP cycle
// and then one IDLE cycle before the next owner is chosen.
module draw_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = 16
) (
  input logic               clk,
  input logic               resetn,
  draw_port_arbiter_if.slave bus
);
  localparam int NUM_REQ = 3;
  localparam logic [TMR_W-1:0] WD_LIM = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [1:0]         last, last_nxt;
  logic [TMR_W-1:0]   wdog, wdog_nxt;
  logic               terr, terr_nxt;

  // Round-robin pick: scan last+1, last+2, last+3 (mod 3); first set req wins.
  logic       found;
  logic [1:0] pick, cand;
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == 2'(NUM_REQ - 1)) ? 2'd0 : cand + 2'd1;
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Only the owner's done/req bits count; the others are masked off by grant.
  logic rel_done, rel_drop, rel_wd;
  assign rel_done = |(grant_q & bus.done);
  assign rel_drop = ~|(grant_q & bus.req);
  assign rel_wd   = (wdog == WD_LIM);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      grant_q <= '0;
      last    <= 2'd2;
      wdog    <= '0;
      terr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last    <= last_nxt;
      wdog    <= wdog_nxt;
      terr    <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last;
    wdog_nxt  = wdog;
    terr_nxt  = terr;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = NUM_REQ'(1) << pick;
          last_nxt  = pick;
          wdog_nxt  = '0;
          state_nxt = OWN;
        end
      end
      OWN: begin
        // Saturate so a huge TMR_W vs small limit can never wrap past it.
        if (wdog != WD_LIM) wdog_nxt = wdog + TMR_W'(1);
        if (rel_done || rel_drop || rel_wd) begin
          grant_nxt = '0;
          state_nxt = GAP;
          // A watchdog hit that coincides with a clean release is not an error.
          if (rel_wd && !rel_done && !rel_drop) terr_nxt = 1'b1;
        end
      end
      GAP: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Forwarding is a pure AND-OR of the registered one-hot grant, so a
  // non-granted requester can never reach the adapter.
  logic [7:0] x_fwd;
  logic [6:0] y_fwd;
  logic [2:0] c_fwd;
  always_comb begin
    x_fwd = '0;
    y_fwd = '0;
    c_fwd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        x_fwd = x_fwd | bus.x_in[8*i +: 8];
        y_fwd = y_fwd | bus.y_in[7*i +: 7];
        c_fwd = c_fwd | bus.color_in[3*i +: 3];
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.x_out       = x_fwd;
  assign bus.y_out       = y_fwd;
  assign bus.color_out   = c_fwd;
  assign bus.writeEn     = |(grant_q & bus.plot_in);
  assign bus.busy        = (state == OWN);
  assign bus.timeout_err = terr;
endmodule

// File: doc/draw_port_arbiter.md
Name: draw_port_arbiter

Overview:
- Shares the single VGA adapter plot port (x, y, colour, writeEn) between three drawing requesters: top paddle, bottom paddle and ball.
- Each requester raises req for one erase or draw pass, drives its pixel stream while granted, and pulses done at the end of the pass.
- The arbiter grants one requester at a time, round-robin, and forwards the granted stream to the adapter.
- A watchdog reclaims the port from a requester that never finishes.

Parameters:
- TIMEOUT_CYCLES, 64, maximum number of cycles a grant may be held before it is forcibly revoked (16-pixel paddle pass plus margin); legal range 2..65535.
- TMR_W, 16, width of the watchdog counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- req  in  3  per-requester request; bit0 = paddle_top, bit1 = paddle_bottom, bit2 = ball.
- done  in  3  per-requester end-of-pass pulse; the arbiter honours only the bit belonging to the current grant.
- x_in  in  24  packed x coordinates; requester i uses bits [8i+7:8i].
- y_in  in  21  packed y coordinates; requester i uses bits [7i+6:7i].
- color_in  in  9  packed colours; requester i uses bits [3i+2:3i].
- plot_in  in  3  per-requester write strobe.
- grant  out  3  one-hot grant, registered.
- x_out  out  8  forwarded x.
- y_out  out  7  forwarded y.
- color_out  out  3  forwarded colour.
- writeEn  out  1  forwarded plot strobe to the VGA adapter.
- busy  out  1  high while any grant is held.
- timeout_err  out  1  sticky watchdog-expired flag.

Behaviour:
- Reset values, applied at the clk edge with resetn=0: state=IDLE; grant=000; busy=0; timeout_err=0; round-robin pointer last=2, so requester 0 has first priority; watchdog=0.
- The reset is synchronous. Reset mid-grant drops grant on that edge without waiting for done.
- Forwarding is combinational from grant:
  - grant[i]=1: x_out, y_out and color_out equal requester i's slices; writeEn = plot_in[i].
  - grant=000: x_out=0, y_out=0, color_out=0, writeEn=0.
- There is no path from plot_in of a non-granted requester to writeEn.
- States:
  - IDLE: if req != 000, pick the first set bit scanning last+1, last+2, last+3 (mod 3). Register grant one-hot, set last to the winner, clear the watchdog, go to OWN. If req=000, stay in IDLE.
  - OWN: busy=1. The watchdog increments each cycle. Release on the first cycle where any of these holds: done[g]=1, req[g]=0, or watchdog reaches TIMEOUT_CYCLES-1. On a watchdog release, also set timeout_err=1. Then go to GAP.
  - GAP: one cycle; grant=000, busy=0. Guarantees a blank cycle between owners. Next state is IDLE.
- Latency:
  - req rising in IDLE at edge n gives grant at edge n+1.
  - done at edge k: grant=0 at k+1 (GAP), IDLE at k+2, next grant at k+3.
- Simultaneous events:
  - done and the watchdog limit in the same cycle: treated as a normal release; timeout_err is not set.
  - done from a non-granted requester: ignored.
  - A requester holding req continuously is re-granted only after every other pending requester has been served once.
- Width rules:
  - The watchdog saturates at TIMEOUT_CYCLES-1 and never wraps.
  - The pointer holds only 0..2.
- timeout_err is cleared only by reset.
- The arbiter never modifies coordinates or colour.

Test Plan:
- Reset, then req=001 with done[0] asserted 16 cycles after grant. Required: grant=001 one cycle after req; writeEn follows plot_in[0] for 16 cycles; grant=000 the cycle after done; timeout_err=0.
- req=111 held, each requester pulses done 5 cycles after its grant. Required grant order 001, 010, 100, 001; each grant separated by exactly one GAP cycle plus one IDLE cycle; writeEn never asserted during gaps.
- Grant to requester 1, then done=101 pulsed while granted. Required: no release, grant stays 010; release only on done[1].
- Grant to requester 2 with done never asserted and TIMEOUT_CYCLES=64. Required: grant drops exactly 64 cycles after it rose; timeout_err=1 and stays 1 after later normal passes until resetn=0.
- resetn driven low for one cycle mid-grant with x_in slice = 8'd75 and plot_in=111. Required: grant=000, writeEn=0, x_out=0 on the next cycle; with req=111 still high after reset, the first grant goes to requester 0.
- Requester 0 drops req before done. Required: grant released the following cycle; pending requester 1 granted two cycles later.
